mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
//  MEM-stage data-memory access controller. Consumes EX/MEM register outputs (address = M_ALUResult,
//  store data, read/write strobes) and drives a variable-latency memory over a req/ack handshake.
//  Generates byte enables and lane replication for sw/sh/sb and lane extraction plus extension for
//  lw/lh/lb(u). Holds the pipeline with Stall until the access completes. Feeds MEM_Read to MEM/WB.
// PARAMETERS
//  TIMEOUT   64   max REQ cycles without mem_ack before bus error (1..255)
// PORTS
//  Clk            in   1   clock, rising edge
//  Reset          in   1   asynchronous, active-low reset
//  M_MemRead      in   1   load in MEM stage
//  M_MemWrite     in   1   store in MEM stage (never high together with M_MemRead)
//  M_Size         in   2   00 word, 01 half, 10 byte, 11 treated as word
//  M_Unsigned     in   1   1 = zero-extend loads (lbu/lhu), 0 = sign-extend
//  M_ALUResult    in   32  byte address
//  M_WriteMemData in   32  store data (low bits used for half/byte)
//  mem_req        out  1   request valid; held until mem_ack
//  mem_we         out  1   1 = write
//  mem_addr       out  32  word address {addr[31:2],2'b00}
//  mem_be         out  4   byte enables, bit i = byte lane i (little-endian)
//  mem_wdata      out  32  write data, lanes replicated
//  mem_ack        in   1   access complete; rdata valid same cycle for reads
//  mem_rdata      in   32  read word
//  Stall          out  1   freeze PC, IF/ID, ID/EX, EX/MEM
//  MEM_Read       out  32  extended load result, held until next load completes
//  MisalignExc    out  1   one-cycle pulse: misaligned access, no request issued
//  BusError       out  1   one-cycle pulse: TIMEOUT expired
// BEHAVIOUR
//  States IDLE, REQ, DONE. Reset: state IDLE, counter 0, all outputs 0 (mem_req drops immediately).
//  Alignment: word requires addr[1:0]==0, half requires addr[0]==0, byte always aligned.
//  IDLE: access = M_MemRead|M_MemWrite. Stall = access (combinational).
//   aligned access -> latch addr/be/wdata/we/size/unsigned into regs, go REQ, counter 0.
//   misaligned -> go DONE with MisalignExc=1 in DONE; no mem_req.
//  REQ: mem_req=1, outputs from latched regs (stable while waiting), Stall=1.
//   mem_ack sampled high -> load: MEM_Read <= extended lane; go DONE. Zero-wait ack allowed.
//   counter increments each REQ cycle without ack; counter==TIMEOUT-1 and no ack -> BusError=1 in
//   DONE, load gives MEM_Read <= 0, mem_req drops.
//  DONE: Stall=0 (EX/MEM advances at this edge), mem_req=0, inputs ignored, go IDLE next cycle.
//   Guarantees a held instruction is never issued twice.
//  mem_ack outside REQ ignored. Latency: min 3 cycles IDLE->REQ->DONE; Stall high for 1+N cycles
//  where N = REQ cycles up to and including ack.
//  Byte enables: word 1111; half addr[1]=0 -> 0011, =1 -> 1100; byte 0001 << addr[1:0].
//  Write data: word as-is; half {2{d[15:0]}}; byte {4{d[7:0]}}.
//  Load extract: half lane = rdata[16*addr[1] +:16]; byte lane = rdata[8*addr[1:0] +:8];
//   extend to 32 by M_Unsigned (latched). Word passes through.
//  MisalignExc/BusError high exactly one cycle (DONE). Stores never change MEM_Read.
//  Reset asserted mid-REQ: abort, no write-back of MEM_Read, state IDLE after release.
// TESTING
//  1 sw 0x12345678 @0x100, ack on 3rd REQ cycle -> mem_addr 0x100, be 1111, we 1, Stall high 4 cycles.
//  2 sb data 0x000000AB @0x103 -> mem_addr 0x100, be 1000, wdata 0xABABABAB; MEM_Read unchanged.
//  3 lh @0x102, rdata 0x80010000, Unsigned 0 -> MEM_Read 0xFFFF8001; Unsigned 1 -> 0x00008001.
//  4 lw @0x101 -> mem_req never high, Stall 1 cycle, MisalignExc pulse 1 cycle in DONE.
//  5 lb @0x200, no ack -> mem_req high TIMEOUT cycles, BusError pulse, MEM_Read 0, back to IDLE.
//  6 Reset low during REQ -> mem_req, Stall, outputs 0 same cycle; after release, new lw completes.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller: turns EX/MEM load/store strobes into a
// req/ack memory transaction, stalls the pipeline until it completes, and extends load data.
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        M_MemRead,
    input  logic        M_MemWrite,
    input  logic [1:0]  M_Size,
    input  logic        M_Unsigned,
    input  logic [31:0] M_ALUResult,
    input  logic [31:0] M_WriteMemData,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        Stall,
    output logic [31:0] MEM_Read,
    output logic        MisalignExc,
    output logic        BusError
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] mem_read_q, mem_read_d;
    logic        misalign_q, misalign_d;
    logic        buserr_q, buserr_d;

    logic        access;
    logic        aligned_in;
    logic [3:0]  be_in;
    logic [31:0] wdata_in;
    logic [31:0] load_ext;
    logic        stall_c;

    assign access = M_MemRead | M_MemWrite;

    // Alignment, byte enables and lane replication from the incoming EX/MEM values.
    // NOTE: every signal assigned in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        aligned_in = 1'b1;
        be_in      = 4'b1111;
        wdata_in   = M_WriteMemData;
        case (M_Size)
            SZ_HALF: begin
                aligned_in = ~M_ALUResult[0];
                be_in      = M_ALUResult[1] ? 4'b1100 : 4'b0011;
                wdata_in   = {2{M_WriteMemData[15:0]}};
            end
            SZ_BYTE: begin
                aligned_in = 1'b1;
                be_in      = 4'b0001 << M_ALUResult[1:0];
                wdata_in   = {4{M_WriteMemData[7:0]}};
            end
            default: begin
                aligned_in = (M_ALUResult[1:0] == 2'b00);
            end
        endcase
    end

    // Lane extraction uses the latched size/offset/signedness, not the live inputs.
    always_comb begin
        load_ext = mem_rdata;
        case (size_q)
            SZ_HALF: begin
                logic [15:0] half;
                half     = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
                load_ext = {{16{half[15] & ~uns_q}}, half};
            end
            SZ_BYTE: begin
                logic [7:0] byte_lane;
                case (addr_q[1:0])
                    2'd0:    byte_lane = mem_rdata[7:0];
                    2'd1:    byte_lane = mem_rdata[15:8];
                    2'd2:    byte_lane = mem_rdata[23:16];
                    default: byte_lane = mem_rdata[31:24];
                endcase
                load_ext = {{24{byte_lane[7] & ~uns_q}}, byte_lane};
            end
            default: load_ext = mem_rdata;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        size_d     = size_q;
        uns_d      = uns_q;
        mem_read_d = mem_read_q;
        misalign_d = 1'b0;
        buserr_d   = 1'b0;
        stall_c    = 1'b0;

        case (state_q)
            S_IDLE: begin
                stall_c = access;
                if (access) begin
                    if (aligned_in) begin
                        addr_d  = M_ALUResult;
                        be_d    = be_in;
                        wdata_d = wdata_in;
                        we_d    = M_MemWrite;
                        size_d  = M_Size;
                        uns_d   = M_Unsigned;
                        cnt_d   = 8'd0;
                        state_d = S_REQ;
                    end else begin
                        misalign_d = 1'b1;
                        state_d    = S_DONE;
                    end
                end
            end
            S_REQ: begin
                stall_c = 1'b1;
                if (mem_ack) begin
                    if (!we_q) begin
                        mem_read_d = load_ext;
                    end
                    state_d = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    buserr_d = 1'b1;
                    if (!we_q) begin
                        mem_read_d = 32'h0;
                    end
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            // EX/MEM advances on the edge ending this cycle, so the held instruction is consumed once.
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= 8'd0;
            addr_q     <= 32'h0;
            be_q       <= 4'h0;
            wdata_q    <= 32'h0;
            we_q       <= 1'b0;
            size_q     <= 2'b00;
            uns_q      <= 1'b0;
            mem_read_q <= 32'h0;
            misalign_q <= 1'b0;
            buserr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
            mem_read_q <= mem_read_d;
            misalign_q <= misalign_d;
            buserr_q   <= buserr_d;
        end
    end

    // Bus outputs are driven only while requesting, so reset clears them in the same cycle.
    assign mem_req     = (state_q == S_REQ);
    assign mem_we      = mem_req & we_q;
    assign mem_addr    = mem_req ? {addr_q[31:2], 2'b00} : 32'h0;
    assign mem_be      = mem_req ? be_q : 4'h0;
    assign mem_wdata   = mem_req ? wdata_q : 32'h0;
    assign Stall       = stall_c;
    assign MEM_Read    = mem_read_q;
    assign MisalignExc = misalign_q;
    assign BusError    = buserr_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: the driver queues expected bus and completion records,
// a monitor pops them when the DUT requests memory or releases Stall.
module tb_mem_access_ctrl;

    localparam int TO = 64;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        M_MemRead, M_MemWrite, M_Unsigned;
    logic [1:0]  M_Size;
    logic [31:0] M_ALUResult, M_WriteMemData;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        Stall, MisalignExc, BusError;
    logic [31:0] MEM_Read;

    mem_access_ctrl #(.TIMEOUT(TO)) dut (
        .Clk(Clk), .Reset(Reset),
        .M_MemRead(M_MemRead), .M_MemWrite(M_MemWrite), .M_Size(M_Size),
        .M_Unsigned(M_Unsigned), .M_ALUResult(M_ALUResult), .M_WriteMemData(M_WriteMemData),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .Stall(Stall), .MEM_Read(MEM_Read), .MisalignExc(MisalignExc), .BusError(BusError)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
    } bus_t;

    typedef struct {
        logic [31:0] rd;
        logic        mis;
        logic        berr;
        int          stall;
        int          reqs;
    } res_t;

    bus_t bus_q[$];
    res_t res_q[$];

    int n_vec = 0;
    int n_bad = 0;

    int          ack_after = 0;   // 0 = never acknowledge
    logic [31:0] rdata_cfg = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    // Memory responder: acks on the ack_after-th consecutive REQ cycle.
    initial begin
        int rc;
        rc = 0;
        mem_ack = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(negedge Clk);
            mem_rdata = rdata_cfg;
            if (mem_req === 1'b1) begin
                rc++;
                mem_ack = (ack_after != 0) && (rc == ack_after);
            end else begin
                rc = 0;
                mem_ack = 1'b0;
            end
        end
    end

    // Monitor: samples 1 time unit after each falling edge.
    initial begin
        int   stall_cnt, req_cnt;
        logic prev_stall, bus_active, after_done;
        bus_t cur;
        res_t r;
        stall_cnt = 0; req_cnt = 0;
        prev_stall = 1'b0; bus_active = 1'b0; after_done = 1'b0;
        cur = '{addr: 32'h0, be: 4'h0, we: 1'b0, wdata: 32'h0};
        forever begin
            @(negedge Clk);
            #1;
            if (Reset !== 1'b1) begin
                stall_cnt = 0; req_cnt = 0;
                prev_stall = 1'b0; bus_active = 1'b0; after_done = 1'b0;
                continue;
            end
            if (after_done) begin
                check("exc_pulse_end", {30'h0, MisalignExc, BusError}, 32'h0);
                after_done = 1'b0;
            end
            if (mem_req === 1'b1) begin
                req_cnt++;
                if (!bus_active) begin
                    if (bus_q.size() == 0) begin
                        check("unexpected_req", 32'h1, 32'h0);
                    end else begin
                        cur = bus_q.pop_front();
                    end
                    bus_active = 1'b1;
                end
                check("bus_addr", mem_addr, cur.addr);
                check("bus_be", {28'h0, mem_be}, {28'h0, cur.be});
                check("bus_we", {31'h0, mem_we}, {31'h0, cur.we});
                if (cur.we) check("bus_wdata", mem_wdata, cur.wdata);
            end else begin
                bus_active = 1'b0;
            end
            if (Stall === 1'b1) stall_cnt++;
            if (prev_stall && (Stall === 1'b0)) begin
                if (res_q.size() == 0) begin
                    check("unexpected_done", 32'h1, 32'h0);
                end else begin
                    r = res_q.pop_front();
                    check("mem_read", MEM_Read, r.rd);
                    check("misalign", {31'h0, MisalignExc}, {31'h0, r.mis});
                    check("buserr", {31'h0, BusError}, {31'h0, r.berr});
                    check("stall_cycles", stall_cnt, r.stall);
                    check("req_cycles", req_cnt, r.reqs);
                end
                stall_cnt = 0;
                req_cnt = 0;
                after_done = 1'b1;
            end
            prev_stall = (Stall === 1'b1);
        end
    end

    // Issue one access at posedge+1 and hold it until the DONE cycle.
    task automatic issue(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdata,
                         input int ack_n, input logic [3:0] ebe, input logic [31:0] ewd,
                         input logic [31:0] erd, input logic emis, input logic eberr,
                         input int estall, input int ereq);
        bus_t b;
        res_t r;
        bit   done;
        if (!emis) begin
            b = '{addr: {addr[31:2], 2'b00}, be: ebe, we: wr, wdata: ewd};
            bus_q.push_back(b);
        end
        r = '{rd: erd, mis: emis, berr: eberr, stall: estall, reqs: ereq};
        res_q.push_back(r);
        ack_after = ack_n;
        rdata_cfg = rdata;
        M_MemRead = rd; M_MemWrite = wr; M_Size = sz; M_Unsigned = uns;
        M_ALUResult = addr; M_WriteMemData = wd;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge Clk);
            #2;
            if (Stall === 1'b0) done = 1'b1;
        end
        if (!done) check("access_timeout", 32'h1, 32'h0);
        @(posedge Clk);
        #1;
        M_MemRead = 1'b0; M_MemWrite = 1'b0;
    endtask

    initial begin
        bus_t b;
        Reset = 1'b0;
        M_MemRead = 1'b0; M_MemWrite = 1'b0; M_Size = 2'b00; M_Unsigned = 1'b0;
        M_ALUResult = 32'h0; M_WriteMemData = 32'h0;
        #2;
        check("rst_req", {31'h0, mem_req}, 32'h0);
        check("rst_stall", {31'h0, Stall}, 32'h0);
        check("rst_mem_read", MEM_Read, 32'h0);
        check("rst_exc", {30'h0, MisalignExc, BusError}, 32'h0);
        #11 Reset = 1'b1;
        @(posedge Clk);
        #1;

        //     rd wr  sz     uns addr      wdata         rdata         ack be     exp_wdata     exp_read      mis berr stall req
        issue(0, 1, 2'b00, 0, 32'h100, 32'h12345678, 32'h0,        3, 4'hF, 32'h12345678, 32'h0,        0, 0, 4, 3);
        issue(0, 1, 2'b10, 0, 32'h103, 32'h000000AB, 32'h0,        1, 4'h8, 32'hABABABAB, 32'h0,        0, 0, 2, 1);
        issue(1, 0, 2'b01, 0, 32'h102, 32'h0,        32'h80010000, 1, 4'hC, 32'h0,        32'hFFFF8001, 0, 0, 2, 1);
        issue(1, 0, 2'b01, 1, 32'h102, 32'h0,        32'h80010000, 2, 4'hC, 32'h0,        32'h00008001, 0, 0, 3, 2);
        issue(0, 1, 2'b01, 0, 32'h102, 32'h0000BEEF, 32'h0,        1, 4'hC, 32'hBEEFBEEF, 32'h00008001, 0, 0, 2, 1);
        issue(1, 0, 2'b10, 0, 32'h101, 32'h0,        32'h1234F0FF, 1, 4'h2, 32'h0,        32'hFFFFFFF0, 0, 0, 2, 1);
        issue(1, 0, 2'b10, 1, 32'h103, 32'h0,        32'h7F000000, 2, 4'h8, 32'h0,        32'h0000007F, 0, 0, 3, 2);
        issue(1, 0, 2'b10, 1, 32'h100, 32'h0,        32'h000000F0, 1, 4'h1, 32'h0,        32'h000000F0, 0, 0, 2, 1);
        issue(1, 0, 2'b11, 0, 32'h104, 32'h0,        32'hDEADBEEF, 1, 4'hF, 32'h0,        32'hDEADBEEF, 0, 0, 2, 1);
        issue(1, 0, 2'b00, 0, 32'h101, 32'h0,        32'h0,        1, 4'h0, 32'h0,        32'hDEADBEEF, 1, 0, 1, 0);
        issue(0, 1, 2'b01, 0, 32'h101, 32'h5555,     32'h0,        1, 4'h0, 32'h0,        32'hDEADBEEF, 1, 0, 1, 0);
        issue(0, 1, 2'b00, 0, 32'h102, 32'h5555,     32'h0,        1, 4'h0, 32'h0,        32'hDEADBEEF, 1, 0, 1, 0);
        issue(1, 0, 2'b01, 1, 32'h103, 32'h0,        32'h0,        1, 4'h0, 32'h0,        32'hDEADBEEF, 1, 0, 1, 0);

        // Reset asserted while a load waits in REQ.
        b = '{addr: 32'h300, be: 4'hF, we: 1'b0, wdata: 32'h0};
        bus_q.push_back(b);
        ack_after = 0;
        rdata_cfg = 32'h0;
        M_MemRead = 1'b1; M_Size = 2'b00; M_Unsigned = 1'b0; M_ALUResult = 32'h300;
        @(negedge Clk);
        @(negedge Clk);
        @(negedge Clk);
        #3;
        check("pre_rst_req", {31'h0, mem_req}, 32'h1);
        Reset = 1'b0;
        M_MemRead = 1'b0;
        #1;
        check("midrst_req", {31'h0, mem_req}, 32'h0);
        check("midrst_stall", {31'h0, Stall}, 32'h0);
        check("midrst_addr", mem_addr, 32'h0);
        check("midrst_be", {28'h0, mem_be}, 32'h0);
        check("midrst_mem_read", MEM_Read, 32'h0);
        @(posedge Clk);
        @(posedge Clk);
        #3 Reset = 1'b1;
        @(posedge Clk);
        #1;

        issue(1, 0, 2'b00, 0, 32'h300, 32'h0,        32'hCAFEF00D, 2, 4'hF, 32'h0,        32'hCAFEF00D, 0, 0, 3, 2);
        issue(1, 0, 2'b10, 0, 32'h200, 32'h0,        32'h000000FF, 0, 4'h1, 32'h0,        32'h0,        0, 1, TO + 1, TO);
        issue(0, 1, 2'b10, 0, 32'h202, 32'h0000005A, 32'h0,        1, 4'h4, 32'h5A5A5A5A, 32'h0,        0, 0, 2, 1);

        repeat (3) @(posedge Clk);
        #1;
        check("bus_q_drained", bus_q.size(), 32'h0);
        check("res_q_drained", res_q.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
